// File: rtl/cp0_exc_ctrl_if.sv
// CP0 register access bus between the M-stage pipeline (master) and CP0 (slave).
// Carries the mfc0/mtc0 register number, write enable, write data and read data.
interface cp0_exc_ctrl_if;
   logic [4:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output we, output wdata, input rdata);
   modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: holds SR, Cause,
// EPC and PRId, raises the flush request and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID      = 32'h4D49_5053,
   parameter int unsigned NUM_HWINT = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   cp0_exc_ctrl_if.slave        bus,
   input  logic [31:0]          vpc,
   input  logic                 bd_in,
   input  logic [4:0]           exc_code_in,
   input  logic [NUM_HWINT-1:0] hw_int,
   input  logic                 exl_clr,
   output logic [31:0]          epc_out,
   output logic                 req
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [NUM_HWINT-1:0] im;
   logic                 exl;
   logic                 ie;
   logic                 bd;
   logic [NUM_HWINT-1:0] ip;
   logic [4:0]           exccode;
   logic [31:0]          epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   always_comb begin
      int_req = ie & ~exl & (|(hw_int & im));
      exc_req = (exc_code_in != 5'd0) & ~exl;
      req     = ~reset & (int_req | exc_req);
   end

   always_comb begin
      sr_val    = {16'h0000, im, 8'h00, exl, ie};
      cause_val = {bd, 15'h0000, ip, 3'b000, exccode, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im      <= '0;
         exl     <= 1'b0;
         ie      <= 1'b0;
         bd      <= 1'b0;
         ip      <= '0;
         exccode <= '0;
         epc     <= '0;
      end else begin
         ip <= hw_int;
         if (req) begin
            exl     <= 1'b1;
            bd      <= bd_in;
            exccode <= int_req ? 5'd0 : exc_code_in;
            epc     <= bd_in ? vpc - 32'd4 : vpc;
         end else begin
            if (bus.we) begin
               case (bus.addr)
                  ADDR_SR: begin
                     im  <= bus.wdata[15:10];
                     exl <= bus.wdata[1];
                     ie  <= bus.wdata[0];
                  end
                  ADDR_EPC: epc <= bus.wdata;
                  default: ;
               endcase
            end
            // eret clear comes last so it wins over an SR write in the same cycle
            if (exl_clr) exl <= 1'b0;
         end
      end
   end

   always_comb begin
      case (bus.addr)
         ADDR_SR:    bus.rdata = sr_val;
         ADDR_CAUSE: bus.rdata = cause_val;
         ADDR_EPC:   bus.rdata = epc;
         ADDR_PRID:  bus.rdata = PRID;
         default:    bus.rdata = '0;
      endcase
   end

   // Forward a same-cycle mtc0 EPC so a following eret sees the new target
   always_comb begin
      if (bus.we && bus.addr == ADDR_EPC && !req) epc_out = bus.wdata;
      else                                        epc_out = epc;
   end

endmodule
